// File: rtl/len_counter_gen.sv
// Parametrised sound-channel length counter on the system clock.
// Optional extra-clock quirk enabled by defining LEN_EXTRA_CLOCK_EN.
module len_counter_gen #(
    parameter int LEN_WIDTH = 6,
    parameter int LEN_MAX   = 1 << LEN_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 len_tick,
    input  logic                 len_wr,
    input  logic [LEN_WIDTH-1:0] len_data,
    input  logic                 len_en_wr,
    input  logic                 len_en_data,
    input  logic                 trigger,
    input  logic                 dac_on,
    input  logic                 seq_len_phase,
    output logic                 chan_enable,
    output logic                 len_enable,
    output logic [LEN_WIDTH:0]   len_count
);

    localparam int CW = LEN_WIDTH + 1;
    localparam logic [CW-1:0] MAX_V = CW'(LEN_MAX);
    localparam logic [CW-1:0] ONE   = CW'(1);

    logic [CW-1:0] cnt_nx;
    logic          en_nx;
    logic          ch_nx;

`ifdef LEN_EXTRA_CLOCK_EN
    logic en_rise;
    assign en_rise = len_en_wr & len_en_data & ~len_enable & seq_len_phase;
`else
    logic unused_phase;
    assign unused_phase = seq_len_phase;
`endif

    always_comb begin
        cnt_nx = len_count;
        en_nx  = len_enable;
        ch_nx  = chan_enable;

        if (len_wr)
            cnt_nx = MAX_V - CW'(len_data);

        if (len_en_wr)
            en_nx = len_en_data;

`ifdef LEN_EXTRA_CLOCK_EN
        // Enabling length in the non-clocking half of the sequencer clocks once
        if (en_rise && cnt_nx != '0) begin
            cnt_nx = cnt_nx - ONE;
            if (cnt_nx == '0 && !trigger)
                ch_nx = 1'b0;
        end
`endif

        if (trigger) begin
            if (cnt_nx == '0) begin
`ifdef LEN_EXTRA_CLOCK_EN
                cnt_nx = (en_nx && seq_len_phase) ? MAX_V - ONE : MAX_V;
`else
                cnt_nx = MAX_V;
`endif
            end
            ch_nx = dac_on;
        end else if (len_tick && !len_wr && en_nx && cnt_nx != '0) begin
            cnt_nx = cnt_nx - ONE;
            if (cnt_nx == '0)
                ch_nx = 1'b0;
        end

        if (!dac_on)
            ch_nx = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_count   <= '0;
            len_enable  <= 1'b0;
            chan_enable <= 1'b0;
        end else begin
            len_count   <= cnt_nx;
            len_enable  <= en_nx;
            chan_enable <= ch_nx;
        end
    end

endmodule

// File: tb/tb_len_counter_gen.sv
// Directed bench for len_counter_gen: 6-bit table plus 8-bit and reset sequences.
module tb_len_counter_gen;

`ifdef LEN_EXTRA_CLOCK_EN
    localparam bit XC = 1'b1;
`else
    localparam bit XC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       len_tick = 1'b0;
    logic       len_wr = 1'b0;
    logic [5:0] data6 = '0;
    logic [7:0] data8 = '0;
    logic       len_en_wr = 1'b0;
    logic       len_en_data = 1'b0;
    logic       trigger = 1'b0;
    logic       dac_on = 1'b0;
    logic       seq_len_phase = 1'b0;

    logic       ch6, en6, ch8, en8;
    logic [6:0] cnt6;
    logic [8:0] cnt8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    len_counter_gen #(.LEN_WIDTH(6)) u6 (
        .clk(clk), .rst_n(rst_n), .len_tick(len_tick), .len_wr(len_wr),
        .len_data(data6), .len_en_wr(len_en_wr), .len_en_data(len_en_data),
        .trigger(trigger), .dac_on(dac_on), .seq_len_phase(seq_len_phase),
        .chan_enable(ch6), .len_enable(en6), .len_count(cnt6)
    );

    len_counter_gen #(.LEN_WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .len_tick(len_tick), .len_wr(len_wr),
        .len_data(data8), .len_en_wr(len_en_wr), .len_en_data(len_en_data),
        .trigger(trigger), .dac_on(dac_on), .seq_len_phase(seq_len_phase),
        .chan_enable(ch8), .len_enable(en8), .len_count(cnt8)
    );

    typedef struct {
        logic       tick;
        logic       wr;
        logic [5:0] data;
        logic       en_wr;
        logic       en_data;
        logic       trig;
        logic       dac;
        logic       phase;
        int         cnt;
        logic       en;
        logic       ch;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic tk, input logic wr, input int d,
                       input logic ew, input logic ed, input logic tr,
                       input logic dc, input logic ph, input int c,
                       input logic e, input logic h);
        vec_t v;
        v.tick = tk; v.wr = wr; v.data = 6'(d); v.en_wr = ew;
        v.en_data = ed; v.trig = tr; v.dac = dc; v.phase = ph;
        v.cnt = c; v.en = e; v.ch = h;
        vecs.push_back(v);
    endtask

    // Strobes are driven at the negedge and released just after the posedge
    task automatic step(input logic tk, input logic wr, input logic ew,
                        input logic ed, input logic tr, input logic dc,
                        input logic ph);
        @(negedge clk);
        len_tick = tk; len_wr = wr; len_en_wr = ew; len_en_data = ed;
        trigger = tr; dac_on = dc; seq_len_phase = ph;
        @(posedge clk);
        #1;
        len_tick = 1'b0; len_wr = 1'b0; len_en_wr = 1'b0; trigger = 1'b0;
    endtask

    initial begin
        //   tk wr dat ew ed tr dc ph   cnt en ch
        add(0, 1, 62, 0, 0, 0, 1, 0,   2, 0, 0);
        add(0, 0, 0,  1, 1, 0, 1, 0,   2, 1, 0);
        add(0, 0, 0,  0, 0, 1, 1, 0,   2, 1, 1);
        add(1, 0, 0,  0, 0, 0, 1, 0,   1, 1, 1);
        add(1, 0, 0,  0, 0, 0, 1, 0,   0, 1, 0);
        add(1, 0, 0,  0, 0, 0, 1, 0,   0, 1, 0);
        add(0, 0, 0,  0, 0, 1, 1, 0,  64, 1, 1);
        add(0, 1, 59, 0, 0, 0, 1, 0,   5, 1, 1);
        add(1, 0, 0,  0, 0, 1, 1, 0,   5, 1, 1);
        add(0, 1, 60, 0, 0, 1, 1, 0,   4, 1, 1);
        add(0, 1, 54, 0, 0, 0, 1, 0,  10, 1, 1);
        add(0, 0, 0,  0, 0, 0, 0, 0,  10, 1, 0);
        add(0, 0, 0,  0, 0, 1, 0, 0,  10, 1, 0);
        add(0, 0, 0,  0, 0, 1, 1, 0,  10, 1, 1);
        add(1, 0, 0,  1, 0, 0, 1, 0,  10, 0, 1);
        add(1, 0, 0,  0, 0, 0, 1, 0,  10, 0, 1);
        add(0, 1, 63, 0, 0, 0, 1, 0,   1, 0, 1);
        add(0, 0, 0,  1, 1, 0, 1, 1,  XC ? 0 : 1, 1, XC ? 1'b0 : 1'b1);
        add(0, 0, 0,  0, 0, 1, 1, 1,  XC ? 63 : 1, 1, 1);
        add(0, 1, 0,  0, 0, 0, 1, 0,  64, 1, 1);
        add(1, 0, 0,  0, 0, 0, 1, 0,  63, 1, 1);
        add(0, 0, 0,  1, 1, 0, 1, 1,  63, 1, 1);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_cnt6", int'(cnt6), 0);
        chk("reset_en6", int'(en6), 0);
        chk("reset_ch6", int'(ch6), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            data6 = vecs[i].data;
            step(vecs[i].tick, vecs[i].wr, vecs[i].en_wr, vecs[i].en_data,
                 vecs[i].trig, vecs[i].dac, vecs[i].phase);
            chk($sformatf("vec%0d_cnt", i), int'(cnt6), vecs[i].cnt);
            chk($sformatf("vec%0d_en", i), int'(en6), int'(vecs[i].en));
            chk($sformatf("vec%0d_ch", i), int'(ch6), int'(vecs[i].ch));
        end

        // Asynchronous reset in the middle of a cycle while active
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_cnt6", int'(cnt6), 0);
        chk("async_en6", int'(en6), 0);
        chk("async_ch6", int'(ch6), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1, 0);
        chk("post_rst_tick_cnt6", int'(cnt6), 0);
        chk("post_rst_tick_ch6", int'(ch6), 0);
        chk("post_rst_tick_en6", int'(en6), 0);

        // 8-bit wave format: reload to 256 and full countdown
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 1, 1, 0);
        chk("w8_trig_cnt", int'(cnt8), 256);
        chk("w8_trig_ch", int'(ch8), 1);
        data8 = 8'd100;
        step(0, 1, 0, 0, 0, 1, 0);
        chk("w8_wr100_cnt", int'(cnt8), 156);
        data8 = 8'd0;
        step(0, 1, 1, 1, 0, 1, 0);
        chk("w8_wr0_cnt", int'(cnt8), 256);
        chk("w8_en", int'(en8), 1);
        for (int k = 0; k < 255; k++)
            step(1, 0, 0, 0, 0, 1, 0);
        chk("w8_255_cnt", int'(cnt8), 1);
        chk("w8_255_ch", int'(ch8), 1);
        step(1, 0, 0, 0, 0, 1, 0);
        chk("w8_256_cnt", int'(cnt8), 0);
        chk("w8_256_ch", int'(ch8), 0);
        step(1, 0, 0, 0, 0, 1, 0);
        chk("w8_257_cnt", int'(cnt8), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
